core_inst_seq: RTL and testbench
================================

Name: core_inst_seq

Overview:
- Instruction sequencer that initiates the core's 35-bit instruction interface.
- Accepts a job descriptor (start pulse) plus an activation stream (valid/ready).
- Generates the per-cycle `inst` word and `D_xmem` to load XMem, fill L0, execute, and drain results.
- Sits between the testbench/host side and `core`; consumes the core's `valid` to pace draining.

Parameters:
- row, 8, array rows; activation word is bw*row bits
- bw, 4, activation bit width
- addr_w, 11, XMem/PSUM address width (2048 words)

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle job request, sampled only in IDLE
- mode  input  1  0 = weight-stationary, 1 = output-stationary; copied to inst[34]
- num_words  input  addr_w  number of activation words in the job; 0 = empty job
- x_base  input  addr_w  first XMem address
- psum_base  input  addr_w  first PSUM address
- in_valid  input  1  activation word valid
- in_data  input  bw*row  activation word
- in_ready  output  1  sequencer accepts in_data this cycle
- core_valid  input  1  core output FIFO has data
- inst  output  35  instruction word to core (registered)
- D_xmem  output  bw*row  XMem write data (registered)
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle pulse at job completion

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high.
- inst field map (decided):
  - [34] mode; [33] acc; [32] psum CEN; [31] psum WEN; [30:20] psum addr
  - [19] xmem CEN; [18] xmem WEN; [17:7] xmem addr
  - [6] ofifo_rd; [5] ififo_wr; [4] ififo_rd; [3] l0_rd; [2] l0_wr; [1] execute; [0] load
  - Memory enables are active-low.
- IDLE word: CEN=1, WEN=1 for both memories; all strobes 0; addresses 0; [34] = latched mode.
- Reset values:
  - inst = IDLE word with mode=0; D_xmem = 0.
  - in_ready = 0, busy = 0, done = 0; state = IDLE; counters = 0.
- Output timing: all outputs are registered. A decision made in cycle t appears on inst in cycle t+1.
- States: IDLE, XLOAD, L0LOAD, EXEC, DRAIN, DONE.
- IDLE:
  - On start, latch mode, num_words, x_base and psum_base.
  - If num_words = 0, go to DONE; otherwise go to XLOAD with cnt = 0.
- XLOAD:
  - in_ready = 1 combinationally from state.
  - On each in_valid & in_ready: next inst has xmem CEN=0, WEN=0, addr = x_base+cnt; D_xmem = in_data; cnt++.
  - Cycles without a handshake emit the IDLE word.
  - The handshake with cnt = num_words-1 moves to L0LOAD with cnt = 0; in_ready drops the next cycle.
- L0LOAD:
  - cnt 0..num_words-1: xmem CEN=0, WEN=1, addr = x_base+cnt.
  - l0_wr = 1 one cycle after each read (SRAM read latency 1), i.e. on num_words cycles delayed by one.
  - Total num_words+1 cycles, then go to EXEC.
- EXEC:
  - l0_rd = 1 and execute = 1 for num_words cycles; memories idle.
  - Then go to DRAIN with dcnt = 0.
- DRAIN:
  - Each cycle core_valid = 1: ofifo_rd = 1, psum CEN=0, WEN=0, addr = psum_base+dcnt; dcnt++.
  - acc = 1 when mode = 1.
  - After num_words reads, go to DONE.
  - No timeout: the sequencer waits indefinitely for core_valid.
- DONE: done = 1 for exactly one cycle, emit IDLE word, return to IDLE.
- Address arithmetic: base + cnt is computed modulo 2^addr_w, so addresses wrap from 2047 to 0.
- busy: high in all states except IDLE. start while busy is ignored, not queued.
- Reset mid-job: the next cycle is IDLE with IDLE word on inst; no done pulse; the partial job is abandoned.
- Simultaneous start and reset: reset wins.

Decomposition:
- Shared package:
  - inst field bit-position constants.
  - IDLE word constant.
  - State enum: IDLE..DONE.
  - Function that assembles an inst word from field arguments.
- Sub-module: one natural sub-module, seq_addr_gen. It holds base+counter, gives modulo wrap, and flags last count; instantiated for XMem and PSUM.

Test Plan:
- Reset, then idle 5 cycles -> inst = IDLE word (bits 32, 31, 19, 18 = 1, all others 0); busy = 0; in_ready = 0.
- Job num_words=4, x_base=10, in_valid continuous, data 0x11111111..0x44444444:
  - XMem writes at addresses 10..13 with matching D_xmem on consecutive cycles.
  - 4 l0_wr pulses; 4 execute cycles.
  - With core_valid=1, 4 drains to psum_base..+3.
  - done pulse once.
- Same job with in_valid toggling 1,0,1,0 -> write cycles only follow handshakes; addresses stay contiguous 10..13; no extra writes.
- x_base=2046, num_words=3 -> XMem addresses 2046, 2047, 0.
- mode=1, psum_base=100, core_valid low 6 cycles mid-DRAIN -> DRAIN stalls; inst[34]=1 and acc=1; writes at 100..103; start during job ignored.
- Reset asserted in EXEC -> next cycle IDLE word, busy=0, done never pulses; num_words=0 job -> done one cycle after start, no memory access.

Source files
------------

// File: rtl/core_inst_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : core_inst_seq_pkg
//  Brief    : Shared inst-word layout, state encoding and word builder for
//             the core instruction sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package core_inst_seq_pkg;

  localparam int C_INST_W   = 35;
  localparam int C_FIELD_AW = 11;

  localparam int C_B_MODE     = 34;
  localparam int C_B_ACC      = 33;
  localparam int C_B_P_CEN    = 32;
  localparam int C_B_P_WEN    = 31;
  localparam int C_B_P_ADDR   = 20;
  localparam int C_B_X_CEN    = 19;
  localparam int C_B_X_WEN    = 18;
  localparam int C_B_X_ADDR   = 7;
  localparam int C_B_OFIFO_RD = 6;
  localparam int C_B_IFIFO_WR = 5;
  localparam int C_B_IFIFO_RD = 4;
  localparam int C_B_L0_RD    = 3;
  localparam int C_B_L0_WR    = 2;
  localparam int C_B_EXECUTE  = 1;
  localparam int C_B_LOAD     = 0;

  // Both memories deselected (active-low enables high), mode bit clear.
  localparam logic [C_INST_W-1:0] C_IDLE_WORD = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_XLOAD  = 3'd1,
    S_L0LOAD = 3'd2,
    S_EXEC   = 3'd3,
    S_DRAIN  = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  typedef struct packed {
    logic                  mode;
    logic                  acc;
    logic                  p_cen;
    logic                  p_wen;
    logic [C_FIELD_AW-1:0] p_addr;
    logic                  x_cen;
    logic                  x_wen;
    logic [C_FIELD_AW-1:0] x_addr;
    logic                  ofifo_rd;
    logic                  ififo_wr;
    logic                  ififo_rd;
    logic                  l0_rd;
    logic                  l0_wr;
    logic                  execute;
    logic                  load;
  } inst_f_t;

  function automatic inst_f_t idle_fields(input logic mode);
    inst_f_t f;
    f       = '0;
    f.mode  = mode;
    f.p_cen = 1'b1;
    f.p_wen = 1'b1;
    f.x_cen = 1'b1;
    f.x_wen = 1'b1;
    return f;
  endfunction

  function automatic logic [C_INST_W-1:0] make_inst(input inst_f_t f);
    logic [C_INST_W-1:0] w;
    w                              = '0;
    w[C_B_MODE]                    = f.mode;
    w[C_B_ACC]                     = f.acc;
    w[C_B_P_CEN]                   = f.p_cen;
    w[C_B_P_WEN]                   = f.p_wen;
    w[C_B_P_ADDR +: C_FIELD_AW]    = f.p_addr;
    w[C_B_X_CEN]                   = f.x_cen;
    w[C_B_X_WEN]                   = f.x_wen;
    w[C_B_X_ADDR +: C_FIELD_AW]    = f.x_addr;
    w[C_B_OFIFO_RD]                = f.ofifo_rd;
    w[C_B_IFIFO_WR]                = f.ififo_wr;
    w[C_B_IFIFO_RD]                = f.ififo_rd;
    w[C_B_L0_RD]                   = f.l0_rd;
    w[C_B_L0_WR]                   = f.l0_wr;
    w[C_B_EXECUTE]                 = f.execute;
    w[C_B_LOAD]                    = f.load;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/core_inst_seq_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : seq_addr_gen
//  Brief    : Base + counter address generator with modulo wrap and a
//             last-count flag.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_addr_gen #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_load,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_num,
  input  logic              i_clr,
  input  logic              i_inc,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_base <= '0;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_base <= i_base;
      r_cnt  <= '0;
    end else if (i_clr) begin
      r_cnt  <= '0;
    end else if (i_inc) begin
      r_cnt  <= r_cnt + ADDR_W'(1);
    end
  end

  // Sum truncated to ADDR_W bits, so the address wraps past the top.
  assign o_addr = r_base + r_cnt;
  assign o_last = (r_cnt == i_num - ADDR_W'(1));

endmodule
`default_nettype wire

// File: rtl/core_inst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : core_inst_seq
//  Brief    : Job sequencer driving the core instruction word: XMem load,
//             L0 fill, execute and PSUM drain.
//  Revision : 1.0 - initial release
// ============================================================================
module core_inst_seq
  import core_inst_seq_pkg::*;
#(
  parameter int ROW    = 8,
  parameter int BW     = 4,
  parameter int ADDR_W = 11
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                mode,
  input  logic [ADDR_W-1:0]   num_words,
  input  logic [ADDR_W-1:0]   x_base,
  input  logic [ADDR_W-1:0]   psum_base,
  input  logic                in_valid,
  input  logic [BW*ROW-1:0]   in_data,
  output logic                in_ready,
  input  logic                core_valid,
  output logic [C_INST_W-1:0] inst,
  output logic [BW*ROW-1:0]   D_xmem,
  output logic                busy,
  output logic                done
);

  state_t              r_state;
  logic                r_mode;
  logic [ADDR_W-1:0]   r_num;
  logic                r_l0_tail;
  logic [C_INST_W-1:0] r_inst;
  logic [BW*ROW-1:0]   r_d_xmem;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;

  state_t              w_next;
  inst_f_t             w_f;
  logic                w_accept;
  logic                w_x_inc;
  logic                w_x_clr;
  logic                w_p_inc;
  logic                w_d_load;
  logic                w_tail_next;
  logic                w_prev_rd;
  logic [ADDR_W-1:0]   w_x_addr;
  logic [ADDR_W-1:0]   w_p_addr;
  logic                w_x_last;
  logic                w_p_last;

  assign w_accept  = (r_state == S_IDLE) && start;
  // l0_wr trails each XMem read by one cycle to cover SRAM read latency.
  assign w_prev_rd = !r_inst[C_B_X_CEN] && r_inst[C_B_X_WEN];

  seq_addr_gen #(.ADDR_W(ADDR_W)) u_xmem_addr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_base (x_base),
    .i_num  (r_num),
    .i_clr  (w_x_clr),
    .i_inc  (w_x_inc),
    .o_addr (w_x_addr),
    .o_last (w_x_last)
  );

  seq_addr_gen #(.ADDR_W(ADDR_W)) u_psum_addr (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_accept),
    .i_base (psum_base),
    .i_num  (r_num),
    .i_clr  (1'b0),
    .i_inc  (w_p_inc),
    .o_addr (w_p_addr),
    .o_last (w_p_last)
  );

  always_comb begin
    w_f         = idle_fields(r_mode);
    w_next      = r_state;
    w_x_inc     = 1'b0;
    w_x_clr     = 1'b0;
    w_p_inc     = 1'b0;
    w_d_load    = 1'b0;
    w_tail_next = r_l0_tail;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_f    = idle_fields(mode);
          w_next = (num_words == '0) ? S_DONE : S_XLOAD;
        end
      end
      S_XLOAD: begin
        if (in_valid) begin
          w_f.x_cen  = 1'b0;
          w_f.x_wen  = 1'b0;
          w_f.x_addr = w_x_addr;
          w_d_load   = 1'b1;
          if (w_x_last) begin
            w_x_clr = 1'b1;
            w_next  = S_L0LOAD;
          end else begin
            w_x_inc = 1'b1;
          end
        end
      end
      S_L0LOAD: begin
        w_f.l0_wr = w_prev_rd;
        if (!r_l0_tail) begin
          w_f.x_cen  = 1'b0;
          w_f.x_addr = w_x_addr;
          if (w_x_last) w_tail_next = 1'b1;
          else          w_x_inc     = 1'b1;
        end else begin
          w_tail_next = 1'b0;
          w_x_clr     = 1'b1;
          w_next      = S_EXEC;
        end
      end
      S_EXEC: begin
        w_f.l0_rd   = 1'b1;
        w_f.execute = 1'b1;
        if (w_x_last) begin
          w_x_clr = 1'b1;
          w_next  = S_DRAIN;
        end else begin
          w_x_inc = 1'b1;
        end
      end
      S_DRAIN: begin
        if (core_valid) begin
          w_f.p_cen    = 1'b0;
          w_f.p_wen    = 1'b0;
          w_f.p_addr   = w_p_addr;
          w_f.acc      = r_mode;
          w_f.ofifo_rd = 1'b1;
          w_p_inc      = 1'b1;
          if (w_p_last) w_next = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_mode     <= 1'b0;
      r_num      <= '0;
      r_l0_tail  <= 1'b0;
      r_inst     <= C_IDLE_WORD;
      r_d_xmem   <= '0;
      r_in_ready <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_l0_tail  <= w_tail_next;
      r_inst     <= make_inst(w_f);
      r_in_ready <= (w_next == S_XLOAD);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);
      if (w_accept) begin
        r_mode <= mode;
        r_num  <= num_words;
      end
      if (w_d_load) r_d_xmem <= in_data;
    end
  end

  assign inst     = r_inst;
  assign D_xmem   = r_d_xmem;
  assign in_ready = r_in_ready;
  assign busy     = r_busy;
  assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_core_inst_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_core_inst_seq
//  Brief    : Scoreboard bench for the core instruction sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_core_inst_seq;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, mode, in_valid, core_valid;
  logic        in_ready, busy, done;
  logic [10:0] num_words, x_base, psum_base;
  logic [31:0] in_data, D_xmem;
  logic [34:0] inst;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  core_inst_seq dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .mode       (mode),
    .num_words  (num_words),
    .x_base     (x_base),
    .psum_base  (psum_base),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .core_valid (core_valid),
    .inst       (inst),
    .D_xmem     (D_xmem),
    .busy       (busy),
    .done       (done)
  );

  // Runs one job; expected XMem/PSUM traffic is queued up front and popped as
  // the DUT emits it. Timing-rule breaks are tallied in viol.
  task automatic drive_job(input logic m, input logic [10:0] n, xb, pb,
                           input bit toggle, input int stall_at, input bit poke,
                           input bit fixed_data,
                           output int xw, output int xr, output int l0w, output int ex,
                           output int pw, output int dn, output int viol);
    logic [10:0] exp_xa[$];
    logic [31:0] exp_xd[$];
    logic [10:0] exp_ra[$];
    logic [10:0] exp_pa[$];
    logic [31:0] din[$];
    logic [10:0] a;
    logic [31:0] d;
    bit prev_hs, prev_cv, drain_live, prev_rd, tog, w_xw, w_xr, w_pw, stalled;
    int hs_idx, stall_left, post;
    xw = 0; xr = 0; l0w = 0; ex = 0; pw = 0; dn = 0; viol = 0;
    for (int k = 0; k < int'(n); k++) begin
      a = xb + 11'(k);
      d = fixed_data ? 32'h11111111 * 32'(k + 1) : $urandom;
      exp_xa.push_back(a);
      exp_xd.push_back(d);
      exp_ra.push_back(a);
      exp_pa.push_back(pb + 11'(k));
      din.push_back(d);
    end
    @(negedge clk);
    start = 1'b1; mode = m; num_words = n; x_base = xb; psum_base = pb;
    in_valid = 1'b0; in_data = '0; core_valid = 1'b1;
    prev_hs = 0; prev_cv = 0; drain_live = 0; prev_rd = 0; tog = 1; stalled = 0;
    hs_idx = 0; stall_left = 0; post = 0;
    for (int cyc = 0; cyc < 400 && post < 3; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      w_xw = !inst[19] && !inst[18];
      w_xr = !inst[19] && inst[18];
      w_pw = !inst[32] && !inst[31];
      if (w_xw != prev_hs) viol++;
      if (w_xw) begin
        xw++;
        checks++;
        if (exp_xa.size() == 0) begin
          failures++;
          $display("FAIL xmem_write_extra: addr=%0d data=%h, required no write", inst[17:7], D_xmem);
        end else begin
          a = exp_xa.pop_front();
          d = exp_xd.pop_front();
          if (inst[17:7] !== a || D_xmem !== d) begin
            failures++;
            $display("FAIL xmem_write: addr=%0d data=%h, required addr=%0d data=%h", inst[17:7], D_xmem, a, d);
          end
        end
      end
      if (w_xr) begin
        xr++;
        checks++;
        if (exp_ra.size() == 0) begin
          failures++;
          $display("FAIL xmem_read_extra: addr=%0d, required no read", inst[17:7]);
        end else begin
          a = exp_ra.pop_front();
          if (inst[17:7] !== a) begin
            failures++;
            $display("FAIL xmem_read: addr=%0d, required %0d", inst[17:7], a);
          end
        end
      end
      if (inst[2] != prev_rd) viol++;
      if (inst[2]) l0w++;
      prev_rd = w_xr;
      if (inst[1]) begin
        ex++;
        if (inst[3] !== 1'b1) viol++;
      end
      if (w_pw != (prev_cv && drain_live)) viol++;
      if (w_pw) begin
        pw++;
        checks++;
        if (exp_pa.size() == 0) begin
          failures++;
          $display("FAIL psum_write_extra: addr=%0d, required no write", inst[30:20]);
        end else begin
          a = exp_pa.pop_front();
          if (inst[30:20] !== a || inst[33] !== m || inst[6] !== 1'b1) begin
            failures++;
            $display("FAIL psum_write: addr=%0d acc=%b ofifo_rd=%b, required addr=%0d acc=%b ofifo_rd=1",
                     inst[30:20], inst[33], inst[6], a, m);
          end
        end
      end
      if (inst[34] !== m) viol++;
      if (done) dn++;
      if (dn > 0) post++;
      drain_live = (ex == int'(n)) && (pw < int'(n));
      if (poke && cyc == 4) begin
        start = 1'b1;
        mode  = !m;
      end
      in_valid = toggle ? tog : (hs_idx < int'(n));
      tog      = !tog;
      in_data  = (hs_idx < int'(n)) ? din[hs_idx] : 32'h0;
      prev_hs  = in_valid && in_ready;
      if (prev_hs) hs_idx++;
      if (stall_at >= 0 && !stalled && pw == stall_at) begin
        stalled    = 1;
        stall_left = 6;
      end
      core_valid = (stall_left == 0);
      if (stall_left > 0) stall_left--;
      prev_cv = core_valid;
    end
    in_valid = 1'b0;
    mode     = 1'b0;
    checks++;
    if (dn == 0) begin
      failures++;
      $display("FAIL job_timeout: done pulses=0, required 1 within budget");
    end
    checks++;
    if (exp_xa.size() + exp_ra.size() + exp_pa.size() != 0) begin
      failures++;
      $display("FAIL job_leftover: pending xw=%0d xr=%0d pw=%0d, required 0",
               exp_xa.size(), exp_ra.size(), exp_pa.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; mode = 1'b0; num_words = '0; x_base = '0; psum_base = '0;
    in_valid = 1'b0; in_data = '0; core_valid = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (inst !== IDLE_W) begin
      failures++;
      $display("FAIL reset_inst: got %h, required %h", inst, IDLE_W);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%b in_ready=%b done=%b, required 0 0 0", busy, in_ready, done);
    end
    checks++;
    if (D_xmem !== 32'h0) begin
      failures++;
      $display("FAIL reset_dxmem: got %h, required 0", D_xmem);
    end
  endtask

  task automatic test_basic();
    int xw, xr, l0w, ex, pw, dn, viol;
    drive_job(1'b0, 11'd4, 11'd10, 11'd500, 0, -1, 0, 1, xw, xr, l0w, ex, pw, dn, viol);
    checks++;
    if (xw != 4 || xr != 4) begin
      failures++;
      $display("FAIL basic_xmem: writes=%0d reads=%0d, required 4 4", xw, xr);
    end
    checks++;
    if (l0w != 4 || ex != 4) begin
      failures++;
      $display("FAIL basic_l0_exec: l0_wr=%0d execute=%0d, required 4 4", l0w, ex);
    end
    checks++;
    if (pw != 4 || dn != 1) begin
      failures++;
      $display("FAIL basic_drain: psum=%0d done=%0d, required 4 1", pw, dn);
    end
    checks++;
    if (viol != 0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL basic_timing: violations=%0d busy=%b in_ready=%b, required 0 0 0", viol, busy, in_ready);
    end
  endtask

  task automatic test_toggle_valid();
    int xw, xr, l0w, ex, pw, dn, viol;
    drive_job(1'b0, 11'd4, 11'd10, 11'd20, 1, -1, 0, 0, xw, xr, l0w, ex, pw, dn, viol);
    checks++;
    if (xw != 4 || pw != 4 || dn != 1) begin
      failures++;
      $display("FAIL toggle_counts: xw=%0d pw=%0d done=%0d, required 4 4 1", xw, pw, dn);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL toggle_timing: violations=%0d, required 0", viol);
    end
  endtask

  task automatic test_wrap();
    int xw, xr, l0w, ex, pw, dn, viol;
    drive_job(1'b0, 11'd3, 11'd2046, 11'd2047, 0, -1, 0, 0, xw, xr, l0w, ex, pw, dn, viol);
    checks++;
    if (xw != 3 || xr != 3 || l0w != 3 || ex != 3) begin
      failures++;
      $display("FAIL wrap_counts: xw=%0d xr=%0d l0w=%0d ex=%0d, required 3 3 3 3", xw, xr, l0w, ex);
    end
    checks++;
    if (viol != 0 || dn != 1) begin
      failures++;
      $display("FAIL wrap_timing: violations=%0d done=%0d, required 0 1", viol, dn);
    end
  endtask

  task automatic test_mode1_stall();
    int xw, xr, l0w, ex, pw, dn, viol;
    drive_job(1'b1, 11'd4, 11'd300, 11'd100, 0, 2, 1, 0, xw, xr, l0w, ex, pw, dn, viol);
    checks++;
    if (pw != 4 || dn != 1 || xw != 4) begin
      failures++;
      $display("FAIL mode1_counts: pw=%0d done=%0d xw=%0d, required 4 1 4", pw, dn, xw);
    end
    checks++;
    if (viol != 0) begin
      failures++;
      $display("FAIL mode1_timing: violations=%0d, required 0", viol);
    end
  endtask

  task automatic test_reset_in_exec();
    bit found;
    int bad;
    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_words = 11'd4; x_base = 11'd0; psum_base = 11'd0;
    in_valid = 1'b1; in_data = $urandom; core_valid = 1'b1;
    found = 0;
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (inst[1]) found = 1;
    end
    in_valid = 1'b0;
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL rst_exec_reach: execute seen=0, required 1");
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (inst !== IDLE_W || busy !== 1'b0 || done !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL rst_exec_state: inst=%h busy=%b done=%b, required %h 0 0", inst, busy, done, IDLE_W);
    end
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (done !== 1'b0 || inst !== IDLE_W) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL rst_exec_after: bad cycles=%0d, required 0", bad);
    end
  endtask

  task automatic test_empty_job();
    @(negedge clk);
    start = 1'b1; mode = 1'b0; num_words = 11'd0; x_base = 11'd5; psum_base = 11'd5;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || inst !== IDLE_W) begin
      failures++;
      $display("FAIL empty_done: done=%b busy=%b inst=%h, required 1 1 %h", done, busy, inst, IDLE_W);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || inst !== IDLE_W) begin
      failures++;
      $display("FAIL empty_after: done=%b busy=%b inst=%h, required 0 0 %h", done, busy, inst, IDLE_W);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_toggle_valid();
    test_wrap();
    test_mode1_stall();
    test_reset_in_exec();
    test_empty_job();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
